mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous-read memory (default 16 x 8) between two requesters, port 0 and port 1.
- Uses round-robin arbitration with a valid/ready request handshake.
- Returns read data one cycle after the request is accepted.
- Contains a clear sequencer that sweeps every address with a fill value, on command or after reset.
- Sits between client logic and the memory macro; drives the memory's address, write-data and write-enable inputs.

Parameters:
- AW, 4, address width; DEPTH = 2**AW.
- DW, 8, data width.
- CLR_VAL, 0, fill value written by the clear sweep (DW bits).
- CLR_ON_RST, 1, 1 = start a clear sweep on leaving reset.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- clr  in  1  clear command, single-cycle pulse.
- busy  out  1  high while a clear sweep is in progress.
- clr_done  out  1  one-cycle pulse on the last clear write.
- p0_valid  in  1  port 0 request valid.
- p0_ready  out  1  port 0 request accepted this cycle.
- p0_we  in  1  port 0 request: 1 = write, 0 = read.
- p0_adr  in  AW  port 0 address.
- p0_dat_w  in  DW  port 0 write data.
- p0_rsp_valid  out  1  port 0 read data valid.
- p0_rsp_dat  out  DW  port 0 read data.
- p1_valid, p1_ready, p1_we, p1_adr, p1_dat_w, p1_rsp_valid, p1_rsp_dat: same as port 0, for port 1.
- mem_adr  out  AW  memory address (the memory registers it internally).
- mem_dat_w  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_dat_r  in  DW  memory read data, valid the cycle after mem_adr is presented.

Behaviour:
- States: ARB, CLEAR.
- Reset (rst=0 at a clock edge):
  - Next state: CLEAR if CLR_ON_RST=1, else ARB.
  - Clear counter = 0; last_grant = 1, so port 0 wins the first contention.
  - rsp_valid regs = 0; busy = 0, clr_done = 0.
  - While rst=0: p0_ready = p1_ready = 0 and mem_we = 0.
  - Reset during a sweep aborts it; the sweep restarts from address 0 only if CLR_ON_RST=1.
- ARB, no clr:
  - Grant is combinational, at most one port per cycle.
  - Only one port valid: that port is granted.
  - Both ports valid: the port that is not last_grant is granted.
  - On a grant, last_grant becomes the granted port.
  - Granted port: pX_ready = 1; mem_adr = pX_adr, mem_dat_w = pX_dat_w, mem_we = pX_we.
  - No grant: mem_we = 0; mem_adr holds its previous value.
  - Accepted read in cycle N: pX_rsp_valid = 1 in cycle N+1, and pX_rsp_dat = mem_dat_r (pass-through) in that cycle.
  - Accepted writes produce no response.
  - rsp_dat is don't-care when rsp_valid = 0.
  - Back-to-back accepts every cycle are allowed. Responses have no backpressure.
- ARB with clr = 1:
  - No grant that cycle: both ready = 0, mem_we = 0.
  - Next state CLEAR, counter = 0.
  - A response owed from a read accepted the previous cycle is still delivered.
- CLEAR:
  - busy = 1; both ready = 0.
  - Each cycle: mem_we = 1, mem_adr = counter, mem_dat_w = CLR_VAL; counter increments.
  - Sweep takes exactly DEPTH cycles.
  - On counter = DEPTH-1: clr_done = 1; next state ARB; busy drops the following cycle.
  - clr during CLEAR is ignored (no restart).
  - Counter is AW bits, so wrap is implicit; termination is on DEPTH-1, not on wrap.
- Simultaneous read and write to the same address by different ports are serialized by the grant. The later read returns the earlier write's data (the memory is write-first across cycles).
- Request inputs are held stable by the client until ready; the arbiter does not latch them.

Test Plan:
- CLR_ON_RST=1; release rst; mem preset to 0xFF -> busy = 1 for 16 cycles, mem_adr sweeps 0..15 with mem_we = 1 and data 0x00, clr_done pulses at adr 15, then port 0 read of adr 7 returns 0x00 one cycle after accept.
- Port 0 writes 0xA5 to adr 3; next cycle port 1 reads adr 3 -> p1_ready = 1, p1_rsp_valid the following cycle with p1_rsp_dat = 0xA5, p0_rsp_valid stays 0.
- Both ports hold read requests (p0 adr 1, p1 adr 2) for 4 cycles after reset -> grants alternate p0, p1, p0, p1; each rsp_valid is one cycle after the matching ready.
- clr pulsed in a cycle where p0_valid = 1 -> p0_ready = 0 that cycle; 16 CLEAR cycles; p0 is accepted in the first ARB cycle; a second clr mid-sweep does not extend busy beyond 16 cycles.
- rst asserted at sweep cycle 5 with CLR_ON_RST=0 -> next cycle busy = 0, mem_we = 0, ready works normally, and addresses 5..15 keep their old contents.
- Port 1 alone issues reads every cycle to adr 0..15 -> ready = 1 every cycle, 16 consecutive p1_rsp_valid cycles with data matching the memory contents.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous-read memory between two requesters
//   using round-robin arbitration with a valid/ready request handshake.
//   Read data returns one cycle after accept, passed straight through from
//   the memory. A clear sweep writes CLR_VAL to every address on command
//   (clr) or on leaving reset (CLR_ON_RST=1).
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   clr, busy, clr_done      clear command / sweep in progress / last write
//   pX_valid, pX_ready       request handshake, port X (0 or 1)
//   pX_we, pX_adr, pX_dat_w  request: write enable, address, write data
//   pX_rsp_valid, pX_rsp_dat read response (one cycle after accept)
//   mem_adr, mem_dat_w,      memory macro interface; mem_dat_r is valid
//   mem_we, mem_dat_r        the cycle after mem_adr is presented
module mem_port_arbiter #(
    parameter int          AW         = 4,
    parameter int          DW         = 8,
    parameter logic [DW-1:0] CLR_VAL  = '0,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_done,
    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_dat_w,
    output logic          p0_rsp_valid,
    output logic [DW-1:0] p0_rsp_dat,
    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_dat_w,
    output logic          p1_rsp_valid,
    output logic [DW-1:0] p1_rsp_dat,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_dat_w,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dat_r
);
    localparam int            DEPTH    = 2**AW;
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH-1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t                  state;
    logic [AW-1:0]           cnt;
    logic                    last_grant;   // 0 = port 0, 1 = port 1
    logic [1:0]              rsp_v;
    logic [AW-1:0]           adr_q;        // last presented address, held when idle

    logic [1:0]              req_v, req_we, gnt;
    logic [1:0][AW-1:0]      req_adr;
    logic [1:0][DW-1:0]      req_dat;
    logic                    arb_en;

    assign req_v   = {p1_valid, p0_valid};
    assign req_we  = {p1_we,    p0_we};
    assign req_adr = {p1_adr,   p0_adr};
    assign req_dat = {p1_dat_w, p0_dat_w};

    // A clr in ARB blocks grants in the same cycle it is seen.
    assign arb_en = rst && (state == ARB) && !clr;

    // Under contention the port that did not win last time is granted.
    assign gnt[0] = arb_en && req_v[0] && (!req_v[1] ||  last_grant);
    assign gnt[1] = arb_en && req_v[1] && (!req_v[0] || !last_grant);

    assign p0_ready = gnt[0];
    assign p1_ready = gnt[1];

    // State resets to CLEAR when CLR_ON_RST=1, so busy must be gated by rst.
    assign busy     = rst && (state == CLEAR);
    assign clr_done = busy && (cnt == CNT_LAST);

    assign p0_rsp_valid = rsp_v[0];
    assign p1_rsp_valid = rsp_v[1];
    assign p0_rsp_dat   = mem_dat_r;
    assign p1_rsp_dat   = mem_dat_r;

    always_comb begin
        mem_adr   = adr_q;
        mem_dat_w = req_dat[0];
        mem_we    = 1'b0;
        if (state == CLEAR) begin
            mem_adr   = cnt;
            mem_dat_w = CLR_VAL;
            mem_we    = rst;
        end else if (gnt[0]) begin
            mem_adr   = req_adr[0];
            mem_dat_w = req_dat[0];
            mem_we    = req_we[0];
        end else if (gnt[1]) begin
            mem_adr   = req_adr[1];
            mem_dat_w = req_dat[1];
            mem_we    = req_we[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CLR_ON_RST ? CLEAR : ARB;
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_v      <= '0;
            adr_q      <= '0;
        end else begin
            adr_q <= mem_adr;
            rsp_v <= gnt & ~req_we;
            if (gnt[0])
                last_grant <= 1'b0;
            else if (gnt[1])
                last_grant <= 1'b1;
            case (state)
                ARB: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // clr is ignored here; the sweep always runs to the end.
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance a uses CLR_ON_RST=1 with a
// memory preset to 0xFF; instance b uses CLR_ON_RST=0 with a memory preset
// to 0x10+address. Each memory model registers the address and reads
// asynchronously from that register, giving write-first data across cycles.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance a
    logic       a_rst, a_clr, a_busy, a_clr_done;
    logic       a_p0_valid, a_p0_ready, a_p0_we, a_p0_rsp_valid;
    logic [3:0] a_p0_adr;
    logic [7:0] a_p0_dat_w, a_p0_rsp_dat;
    logic       a_p1_valid, a_p1_ready, a_p1_we, a_p1_rsp_valid;
    logic [3:0] a_p1_adr;
    logic [7:0] a_p1_dat_w, a_p1_rsp_dat;
    logic [3:0] a_mem_adr, a_ra;
    logic [7:0] a_mem_dat_w, a_mem_dat_r;
    logic       a_mem_we;
    logic [7:0] a_mem [16] = '{default: 8'hFF};

    // instance b
    logic       b_rst, b_clr, b_busy, b_clr_done;
    logic       b_p0_valid, b_p0_ready, b_p0_we, b_p0_rsp_valid;
    logic [3:0] b_p0_adr;
    logic [7:0] b_p0_dat_w, b_p0_rsp_dat;
    logic       b_p1_valid, b_p1_ready, b_p1_we, b_p1_rsp_valid;
    logic [3:0] b_p1_adr;
    logic [7:0] b_p1_dat_w, b_p1_rsp_dat;
    logic [3:0] b_mem_adr, b_ra;
    logic [7:0] b_mem_dat_w, b_mem_dat_r;
    logic       b_mem_we;
    logic [7:0] b_mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                               8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

    always @(posedge clk) begin
        if (a_mem_we) a_mem[a_mem_adr] <= a_mem_dat_w;
        a_ra <= a_mem_adr;
    end
    assign a_mem_dat_r = a_mem[a_ra];

    always @(posedge clk) begin
        if (b_mem_we) b_mem[b_mem_adr] <= b_mem_dat_w;
        b_ra <= b_mem_adr;
    end
    assign b_mem_dat_r = b_mem[b_ra];

    mem_port_arbiter #(.AW(4), .DW(8), .CLR_VAL(8'h00), .CLR_ON_RST(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .busy(a_busy), .clr_done(a_clr_done),
        .p0_valid(a_p0_valid), .p0_ready(a_p0_ready), .p0_we(a_p0_we), .p0_adr(a_p0_adr),
        .p0_dat_w(a_p0_dat_w), .p0_rsp_valid(a_p0_rsp_valid), .p0_rsp_dat(a_p0_rsp_dat),
        .p1_valid(a_p1_valid), .p1_ready(a_p1_ready), .p1_we(a_p1_we), .p1_adr(a_p1_adr),
        .p1_dat_w(a_p1_dat_w), .p1_rsp_valid(a_p1_rsp_valid), .p1_rsp_dat(a_p1_rsp_dat),
        .mem_adr(a_mem_adr), .mem_dat_w(a_mem_dat_w), .mem_we(a_mem_we), .mem_dat_r(a_mem_dat_r)
    );

    mem_port_arbiter #(.AW(4), .DW(8), .CLR_VAL(8'h00), .CLR_ON_RST(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .busy(b_busy), .clr_done(b_clr_done),
        .p0_valid(b_p0_valid), .p0_ready(b_p0_ready), .p0_we(b_p0_we), .p0_adr(b_p0_adr),
        .p0_dat_w(b_p0_dat_w), .p0_rsp_valid(b_p0_rsp_valid), .p0_rsp_dat(b_p0_rsp_dat),
        .p1_valid(b_p1_valid), .p1_ready(b_p1_ready), .p1_we(b_p1_we), .p1_adr(b_p1_adr),
        .p1_dat_w(b_p1_dat_w), .p1_rsp_valid(b_p1_rsp_valid), .p1_rsp_dat(b_p1_rsp_dat),
        .mem_adr(b_mem_adr), .mem_dat_w(b_mem_dat_w), .mem_we(b_mem_we), .mem_dat_r(b_mem_dat_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b0; a_clr = 1'b0;
        a_p0_valid = 1'b0; a_p0_we = 1'b0; a_p0_adr = '0; a_p0_dat_w = '0;
        a_p1_valid = 1'b0; a_p1_we = 1'b0; a_p1_adr = '0; a_p1_dat_w = '0;
        b_rst = 1'b0; b_clr = 1'b0;
        b_p0_valid = 1'b0; b_p0_we = 1'b0; b_p0_adr = '0; b_p0_dat_w = '0;
        b_p1_valid = 1'b0; b_p1_we = 1'b0; b_p1_adr = '0; b_p1_dat_w = '0;
        cyc(); cyc();

        // reset state: requests present but nothing accepted
        a_p0_valid = 1'b1; a_p1_valid = 1'b1;
        #1;
        chk("rst_p0_ready", a_p0_ready, 0);
        chk("rst_p1_ready", a_p1_ready, 0);
        chk("rst_mem_we", a_mem_we, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_clr_done", a_clr_done, 0);
        chk("rst_p0_rsp_valid", a_p0_rsp_valid, 0);
        chk("rst_p1_rsp_valid", a_p1_rsp_valid, 0);
        chk("rst_b_busy", b_busy, 0);
        cyc();

        // clear sweep on leaving reset
        a_rst = 1'b1; a_p0_valid = 1'b0; a_p1_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("sweep_busy", a_busy, 1);
            chk("sweep_mem_we", a_mem_we, 1);
            chk("sweep_mem_adr", a_mem_adr, i);
            chk("sweep_mem_dat_w", a_mem_dat_w, 8'h00);
            chk("sweep_clr_done", a_clr_done, (i == 15) ? 1 : 0);
            chk("sweep_p0_ready", a_p0_ready, 0);
            cyc();
        end

        // port 0 reads adr 7 in the first ARB cycle
        a_p0_valid = 1'b1; a_p0_we = 1'b0; a_p0_adr = 4'd7;
        #1;
        chk("post_sweep_busy", a_busy, 0);
        chk("post_sweep_clr_done", a_clr_done, 0);
        chk("rd7_p0_ready", a_p0_ready, 1);
        chk("rd7_mem_adr", a_mem_adr, 7);
        chk("rd7_mem_we", a_mem_we, 0);
        cyc();
        a_p0_valid = 1'b0;
        #1;
        chk("rd7_rsp_valid", a_p0_rsp_valid, 1);
        chk("rd7_rsp_dat", a_p0_rsp_dat, 8'h00);
        chk("rd7_p1_rsp_valid", a_p1_rsp_valid, 0);
        chk("idle_mem_adr_hold", a_mem_adr, 7);
        cyc();

        // p0 writes A5 to adr 3, then p1 reads it back
        a_p0_valid = 1'b1; a_p0_we = 1'b1; a_p0_adr = 4'd3; a_p0_dat_w = 8'hA5;
        #1;
        chk("wr3_p0_ready", a_p0_ready, 1);
        chk("wr3_mem_we", a_mem_we, 1);
        chk("wr3_mem_adr", a_mem_adr, 3);
        chk("wr3_mem_dat_w", a_mem_dat_w, 8'hA5);
        cyc();
        a_p0_valid = 1'b0; a_p0_we = 1'b0;
        a_p1_valid = 1'b1; a_p1_we = 1'b0; a_p1_adr = 4'd3;
        #1;
        chk("rd3_p1_ready", a_p1_ready, 1);
        chk("wr3_no_rsp", a_p0_rsp_valid, 0);
        chk("rd3_mem_we", a_mem_we, 0);
        cyc();
        a_p1_valid = 1'b0;
        #1;
        chk("rd3_p1_rsp_valid", a_p1_rsp_valid, 1);
        chk("rd3_p1_rsp_dat", a_p1_rsp_dat, 8'hA5);
        chk("rd3_p0_rsp_valid", a_p0_rsp_valid, 0);
        cyc();

        // p1 read, then clr with p0 pending: owed response still arrives
        a_p1_valid = 1'b1; a_p1_adr = 4'd3;
        #1;
        chk("pre_clr_p1_ready", a_p1_ready, 1);
        cyc();
        a_p1_valid = 1'b0;
        a_clr = 1'b1; a_p0_valid = 1'b1; a_p0_we = 1'b0; a_p0_adr = 4'd3;
        #1;
        chk("clr_p0_ready", a_p0_ready, 0);
        chk("clr_mem_we", a_mem_we, 0);
        chk("clr_busy", a_busy, 0);
        chk("clr_owed_rsp_valid", a_p1_rsp_valid, 1);
        chk("clr_owed_rsp_dat", a_p1_rsp_dat, 8'hA5);
        cyc();
        for (int i = 0; i < 16; i++) begin
            a_clr = (i == 5);
            #1;
            chk("clr_sweep_busy", a_busy, 1);
            chk("clr_sweep_p0_ready", a_p0_ready, 0);
            chk("clr_sweep_mem_adr", a_mem_adr, i);
            chk("clr_sweep_clr_done", a_clr_done, (i == 15) ? 1 : 0);
            cyc();
        end
        a_clr = 1'b0;
        #1;
        chk("clr_end_busy", a_busy, 0);
        chk("clr_end_p0_ready", a_p0_ready, 1);
        chk("clr_end_mem_adr", a_mem_adr, 3);
        cyc();
        a_p0_valid = 1'b0;
        #1;
        chk("clr_end_rsp_valid", a_p0_rsp_valid, 1);
        chk("clr_end_rsp_dat", a_p0_rsp_dat, 8'h00);
        cyc();

        // back-to-back p0 writes of 0x30+adr, then p1 streams reads 0..15
        for (int i = 0; i < 16; i++) begin
            a_p0_valid = 1'b1; a_p0_we = 1'b1; a_p0_adr = 4'(i); a_p0_dat_w = 8'(8'h30 + i);
            #1;
            chk("bw_p0_ready", a_p0_ready, 1);
            cyc();
        end
        a_p0_valid = 1'b0; a_p0_we = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            a_p1_valid = (k < 16); a_p1_we = 1'b0; a_p1_adr = 4'(k);
            #1;
            if (k < 16) chk("br_p1_ready", a_p1_ready, 1);
            if (k > 0) begin
                chk("br_p1_rsp_valid", a_p1_rsp_valid, 1);
                chk("br_p1_rsp_dat", a_p1_rsp_dat, 8'h30 + k - 1);
            end
            cyc();
        end
        a_p1_valid = 1'b0;
        #1;
        chk("br_done_rsp_valid", a_p1_rsp_valid, 0);

        // instance b: alternating grants under contention after reset
        b_rst = 1'b1;
        b_p0_valid = 1'b1; b_p0_adr = 4'd1;
        b_p1_valid = 1'b1; b_p1_adr = 4'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_p0_ready", b_p0_ready, (c % 2 == 0) ? 1 : 0);
            chk("rr_p1_ready", b_p1_ready, (c % 2 == 1) ? 1 : 0);
            chk("rr_busy", b_busy, 0);
            if (c == 0) begin
                chk("rr_p0_rsp_valid0", b_p0_rsp_valid, 0);
                chk("rr_p1_rsp_valid0", b_p1_rsp_valid, 0);
            end else if (c % 2 == 1) begin
                chk("rr_p0_rsp_valid", b_p0_rsp_valid, 1);
                chk("rr_p0_rsp_dat", b_p0_rsp_dat, 8'h11);
                chk("rr_p1_rsp_idle", b_p1_rsp_valid, 0);
            end else begin
                chk("rr_p1_rsp_valid", b_p1_rsp_valid, 1);
                chk("rr_p1_rsp_dat", b_p1_rsp_dat, 8'h12);
                chk("rr_p0_rsp_idle", b_p0_rsp_valid, 0);
            end
            cyc();
        end
        b_p0_valid = 1'b0; b_p1_valid = 1'b0;
        #1;
        chk("rr_last_p1_rsp_valid", b_p1_rsp_valid, 1);
        chk("rr_last_p1_rsp_dat", b_p1_rsp_dat, 8'h12);
        chk("rr_last_p0_rsp_valid", b_p0_rsp_valid, 0);
        cyc();

        // instance b: reset at sweep cycle 5 aborts the sweep
        b_clr = 1'b1;
        #1;
        chk("b_clr_busy", b_busy, 0);
        cyc();
        b_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("b_sweep_busy", b_busy, 1);
            chk("b_sweep_mem_adr", b_mem_adr, i);
            chk("b_sweep_mem_we", b_mem_we, 1);
            cyc();
        end
        b_rst = 1'b0; b_p0_valid = 1'b1; b_p0_we = 1'b0; b_p0_adr = 4'd5;
        #1;
        chk("b_abort_mem_we", b_mem_we, 0);
        chk("b_abort_busy", b_busy, 0);
        chk("b_abort_p0_ready", b_p0_ready, 0);
        cyc();
        b_rst = 1'b1;
        #1;
        chk("b_after_busy", b_busy, 0);
        chk("b_after_mem_we", b_mem_we, 0);
        chk("b_after_p0_ready", b_p0_ready, 1);
        cyc();
        b_p0_adr = 4'd4;
        #1;
        chk("b_rd5_rsp_valid", b_p0_rsp_valid, 1);
        chk("b_rd5_rsp_dat", b_p0_rsp_dat, 8'h15);
        chk("b_rd4_p0_ready", b_p0_ready, 1);
        cyc();
        b_p0_adr = 4'd15;
        #1;
        chk("b_rd4_rsp_dat", b_p0_rsp_dat, 8'h00);
        cyc();
        b_p0_valid = 1'b0;
        #1;
        chk("b_rd15_rsp_valid", b_p0_rsp_valid, 1);
        chk("b_rd15_rsp_dat", b_p0_rsp_dat, 8'h1F);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
